// File: rtl/eth_frame_codec.sv
// RMII (2-bit) Ethernet frame codec.
// TX: frames a payload dibit stream as preamble/SFD, MAC header, payload,
//     CRC-32 FCS and inter-frame gap, one dibit per clock.
// RX: reorders each received byte MSB-dibit-first and checks the FCS residue.
// Handshake (TX upstream): tx_stall is registered; in any cycle where
// tx_stall=0 the dibit on tx_axiid (qualified by tx_axiiv) is consumed at the
// next rising clock edge. With tx_stall=1 upstream must hold its dibit.
// tx_axiiv=0 while tx_stall=0 produces a zero padding dibit on the wire.
module eth_frame_codec #(
  parameter logic [47:0] SRC_MAC       = 48'h69_69_5A_06_54_91,
  parameter logic [47:0] DST_MAC       = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [15:0] ETHERTYPE     = 16'h0800,
  parameter int unsigned PAYLOAD_BYTES = 46,
  parameter int unsigned IFG_DIBITS    = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cancelled,
  input  logic       tx_axiiv,
  input  logic [1:0] tx_axiid,
  output logic       tx_stall,
  output logic       phy_txen,
  output logic [1:0] phy_txd,
  input  logic       rx_axiiv,
  input  logic [1:0] rx_axiid,
  output logic       rx_axiov,
  output logic [1:0] rx_axiod,
  output logic       done,
  output logic       kill
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_HDR  = 3'd2;
  localparam logic [2:0] ST_PAY  = 3'd3;
  localparam logic [2:0] ST_FCS  = 3'd4;
  localparam logic [2:0] ST_IFG  = 3'd5;

  localparam logic [15:0]  PRE_LAST = 16'd31;
  localparam logic [15:0]  HDR_LAST = 16'd55;
  localparam logic [15:0]  PAY_LAST = 16'(PAYLOAD_BYTES * 4 - 1);
  localparam logic [15:0]  FCS_LAST = 16'd15;
  localparam logic [15:0]  IFG_LAST = 16'(IFG_DIBITS - 1);
  localparam logic [31:0]  CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0]  CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};

  // Reflected CRC-32 step over one dibit, bit 0 first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Header dibit idx: bytes MSB-first across the field, bits LSB-first in a byte.
  function automatic logic [1:0] hdr_dibit(input logic [5:0] idx);
    logic [111:0] sh;
    logic [7:0]   b;
    sh = HDR << {idx[5:2], 3'b000};
    b  = sh[111:104];
    case (idx[1:0])
      2'd0:    return b[1:0];
      2'd1:    return b[3:2];
      2'd2:    return b[5:4];
      default: return b[7:6];
    endcase
  endfunction

  // ---------------- TX path ----------------
  logic [2:0]  tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [31:0] tx_crc_q, tx_crc_d;
  logic        phy_txen_q, phy_txen_d;
  logic [1:0]  phy_txd_q, phy_txd_d;
  logic        tx_stall_q, tx_stall_d;
  logic [31:0] fcs_sh;
  logic        tx_active;

  // TX sequencing; the wire outputs are computed from the next state so the
  // registered outputs line up with tx_state_q.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_crc_d   = tx_crc_q;
    phy_txen_d = 1'b0;
    phy_txd_d  = 2'b00;
    fcs_sh     = 32'd0;
    tx_active  = (tx_state_q == ST_PRE) || (tx_state_q == ST_HDR) ||
                 (tx_state_q == ST_PAY) || (tx_state_q == ST_FCS);

    case (tx_state_q)
      ST_IDLE: if (tx_axiiv) begin tx_state_d = ST_PRE; tx_cnt_d = 16'd0; end
      ST_PRE:
        if (tx_cnt_q == PRE_LAST) begin tx_state_d = ST_HDR; tx_cnt_d = 16'd0; end
        else tx_cnt_d = tx_cnt_q + 16'd1;
      ST_HDR:
        if (tx_cnt_q == HDR_LAST) begin tx_state_d = ST_PAY; tx_cnt_d = 16'd0; end
        else tx_cnt_d = tx_cnt_q + 16'd1;
      ST_PAY:
        if (tx_cnt_q == PAY_LAST) begin tx_state_d = ST_FCS; tx_cnt_d = 16'd0; end
        else tx_cnt_d = tx_cnt_q + 16'd1;
      ST_FCS:
        if (tx_cnt_q == FCS_LAST) begin tx_state_d = ST_IFG; tx_cnt_d = 16'd0; end
        else tx_cnt_d = tx_cnt_q + 16'd1;
      ST_IFG:
        if (tx_cnt_q == IFG_LAST) begin
          // The gap's last cycle doubles as the idle check so back-to-back
          // frames are separated by exactly IFG_DIBITS quiet cycles.
          tx_state_d = tx_axiiv ? ST_PRE : ST_IDLE;
          tx_cnt_d   = 16'd0;
        end else tx_cnt_d = tx_cnt_q + 16'd1;
      default: begin tx_state_d = ST_IDLE; tx_cnt_d = 16'd0; end
    endcase

    if (cancelled && tx_active) begin
      tx_state_d = ST_IFG;
      tx_cnt_d   = 16'd0;
    end

    case (tx_state_d)
      ST_PRE: begin
        phy_txen_d = 1'b1;
        phy_txd_d  = (tx_cnt_d == PRE_LAST) ? 2'b11 : 2'b01;
        tx_crc_d   = CRC_INIT;
      end
      ST_HDR: begin
        phy_txen_d = 1'b1;
        phy_txd_d  = hdr_dibit(tx_cnt_d[5:0]);
        tx_crc_d   = crc_dibit(tx_crc_q, phy_txd_d);
      end
      ST_PAY: begin
        phy_txen_d = 1'b1;
        phy_txd_d  = tx_axiiv ? tx_axiid : 2'b00;
        tx_crc_d   = crc_dibit(tx_crc_q, phy_txd_d);
      end
      ST_FCS: begin
        phy_txen_d = 1'b1;
        fcs_sh     = (~tx_crc_q) >> {tx_cnt_d[3:0], 1'b0};
        phy_txd_d  = fcs_sh[1:0];
      end
      default: tx_crc_d = CRC_INIT;
    endcase

    // Open the stall one cycle ahead: the dibit presented while tx_stall=0
    // is the one registered onto the wire in the following payload cycle.
    tx_stall_d = !(((tx_state_d == ST_HDR) && (tx_cnt_d == HDR_LAST)) ||
                   ((tx_state_d == ST_PAY) && (tx_cnt_d != PAY_LAST)));
  end

  // TX state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_crc_q   <= CRC_INIT;
      phy_txen_q <= 1'b0;
      phy_txd_q  <= 2'b00;
      tx_stall_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_crc_q   <= tx_crc_d;
      phy_txen_q <= phy_txen_d;
      phy_txd_q  <= phy_txd_d;
      tx_stall_q <= tx_stall_d;
    end
  end

  // ---------------- RX path ----------------
  logic [1:0]  rx_cnt_q, rx_cnt_d;
  logic [5:0]  rx_col_q, rx_col_d;
  logic [5:0]  rx_out_q, rx_out_d;
  logic [1:0]  rx_rem_q, rx_rem_d;
  logic        rx_axiov_q, rx_axiov_d;
  logic [1:0]  rx_axiod_q, rx_axiod_d;
  logic        rx_prev_q, rx_prev_d;
  logic [31:0] rx_crc_q, rx_crc_d;
  logic        done_q, done_d;
  logic        kill_q, kill_d;

  // Byte reorder (collect buffer + drain buffer) and FCS residue check.
  always_comb begin
    rx_cnt_d   = rx_cnt_q;
    rx_col_d   = rx_col_q;
    rx_out_d   = rx_out_q;
    rx_rem_d   = rx_rem_q;
    rx_axiov_d = 1'b0;
    rx_axiod_d = 2'b00;
    rx_prev_d  = rx_axiiv;
    rx_crc_d   = rx_crc_q;
    done_d     = done_q;
    kill_d     = kill_q;

    // Drain the remaining dibits of the previous byte (d2, d1, d0).
    if (rx_rem_q != 2'd0) begin
      rx_axiov_d = 1'b1;
      rx_axiod_d = rx_out_q[5:4];
      rx_out_d   = {rx_out_q[3:0], 2'b00};
      rx_rem_d   = rx_rem_q - 2'd1;
    end

    // Collect; on the fourth dibit emit it directly and hand d2..d0 to the
    // drain buffer, which is empty by then even for back-to-back bytes.
    if (rx_axiiv) begin
      if (rx_cnt_q == 2'd3) begin
        rx_axiov_d = 1'b1;
        rx_axiod_d = rx_axiid;
        rx_out_d   = rx_col_q;
        rx_rem_d   = 2'd3;
        rx_cnt_d   = 2'd0;
      end else begin
        case (rx_cnt_q)
          2'd0:    rx_col_d[1:0] = rx_axiid;
          2'd1:    rx_col_d[3:2] = rx_axiid;
          default: rx_col_d[5:4] = rx_axiid;
        endcase
        rx_cnt_d = rx_cnt_q + 2'd1;
      end
    end else begin
      rx_cnt_d = 2'd0;  // drop any partial byte
    end

    if (rx_axiiv && !rx_prev_q) begin
      rx_crc_d = crc_dibit(CRC_INIT, rx_axiid);
      done_d   = 1'b0;
      kill_d   = 1'b0;
    end else if (rx_axiiv) begin
      rx_crc_d = crc_dibit(rx_crc_q, rx_axiid);
    end else if (rx_prev_q) begin
      done_d   = 1'b1;
      kill_d   = (rx_crc_q != CRC_RESIDUE);
      rx_crc_d = CRC_INIT;
    end
  end

  // RX registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_cnt_q   <= 2'd0;
      rx_col_q   <= 6'd0;
      rx_out_q   <= 6'd0;
      rx_rem_q   <= 2'd0;
      rx_axiov_q <= 1'b0;
      rx_axiod_q <= 2'b00;
      rx_prev_q  <= 1'b0;
      rx_crc_q   <= CRC_INIT;
      done_q     <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      rx_cnt_q   <= rx_cnt_d;
      rx_col_q   <= rx_col_d;
      rx_out_q   <= rx_out_d;
      rx_rem_q   <= rx_rem_d;
      rx_axiov_q <= rx_axiov_d;
      rx_axiod_q <= rx_axiod_d;
      rx_prev_q  <= rx_prev_d;
      rx_crc_q   <= rx_crc_d;
      done_q     <= done_d;
      kill_q     <= kill_d;
    end
  end

  assign tx_stall = tx_stall_q;
  assign phy_txen = phy_txen_q;
  assign phy_txd  = phy_txd_q;
  assign rx_axiov = rx_axiov_q;
  assign rx_axiod = rx_axiod_q;
  assign done     = done_q;
  assign kill     = kill_q;

endmodule

// File: tb/tb_eth_frame_codec.sv
// Testbench for eth_frame_codec: TX framing against a byte-level frame model,
// RX reorder/FCS check through a loopback of the captured TX frames.
module tb_eth_frame_codec;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cancelled = 1'b0;
  logic       tx_axiiv = 1'b0;
  logic [1:0] tx_axiid = 2'b00;
  logic       rx_axiiv = 1'b0;
  logic [1:0] rx_axiid = 2'b00;
  logic       tx_stall, phy_txen, rx_axiov, done, kill;
  logic [1:0] phy_txd, rx_axiod;

  always #5 clk = ~clk;

  eth_frame_codec dut (
    .clk(clk), .rst(rst), .cancelled(cancelled),
    .tx_axiiv(tx_axiiv), .tx_axiid(tx_axiid), .tx_stall(tx_stall),
    .phy_txen(phy_txen), .phy_txd(phy_txd),
    .rx_axiiv(rx_axiiv), .rx_axiid(rx_axiid),
    .rx_axiov(rx_axiov), .rx_axiod(rx_axiod),
    .done(done), .kill(kill)
  );

  localparam logic [47:0] M_DST  = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] M_SRC  = 48'h69_69_5A_06_54_91;
  localparam logic [15:0] M_TYPE = 16'h0800;
  localparam int PB = 46;
  localparam int PD = PB * 4;

  int total = 0;
  int bad   = 0;

  logic [1:0] slot_d [PD];
  bit         slot_v [PD];
  logic [1:0] wire_q[$];
  logic [1:0] exp_q[$];
  logic [1:0] rx_in[$];
  int         stall_low;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Plain byte-wise reflected CRC-32, no final inversion.
  function automatic logic [31:0] crc_raw(input logic [7:0] bq[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (bq[i]) begin
      c = c ^ {24'd0, bq[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  // Expected wire image of the frame built from the current payload slots.
  task automatic build_tx_exp();
    logic [7:0]   fr[$];
    logic [111:0] hdr;
    logic [31:0]  fcs;
    logic [7:0]   b;
    hdr = {M_DST, M_SRC, M_TYPE};
    for (int i = 0; i < 14; i++) fr.push_back(hdr[111 - 8*i -: 8]);
    for (int j = 0; j < PB; j++) begin
      b = 8'd0;
      for (int k = 0; k < 4; k++) if (slot_v[4*j+k]) b[2*k +: 2] = slot_d[4*j+k];
      fr.push_back(b);
    end
    fcs = ~crc_raw(fr);
    for (int i = 0; i < 4; i++) fr.push_back(fcs[8*i +: 8]);
    exp_q.delete();
    for (int i = 0; i < 31; i++) exp_q.push_back(2'b01);
    exp_q.push_back(2'b11);
    foreach (fr[i]) for (int k = 0; k < 4; k++) exp_q.push_back(fr[i][2*k +: 2]);
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst = 1'b0; cancelled = 1'b0; tx_axiiv = 1'b0; tx_axiid = 2'b00;
    rx_axiiv = 1'b0; rx_axiid = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Feed the payload slots honouring tx_stall and capture the frame dibits.
  task automatic run_tx(input string tag);
    int slot;
    bit started, ended;
    wire_q.delete(); stall_low = 0; slot = 0; started = 0; ended = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (phy_txen) begin started = 1; wire_q.push_back(phy_txd); end
      else if (started) begin ended = 1; break; end
      if (!tx_stall) stall_low++;
      if (!tx_stall && slot < PD) begin
        tx_axiiv = slot_v[slot]; tx_axiid = slot_d[slot]; slot++;
      end else if (slot == 0) begin
        tx_axiiv = 1'b1; tx_axiid = slot_d[0];
      end else begin
        tx_axiiv = 1'b0; tx_axiid = 2'b00;
      end
    end
    chk({tag, "_frame_end"}, ended, 1);
  endtask

  task automatic check_tx(input string tag);
    int nm [4];
    int seg, n;
    build_tx_exp();
    for (int s = 0; s < 4; s++) nm[s] = 0;
    chk({tag, "_stall_low"}, stall_low, 184);
    chk({tag, "_txen_cycles"}, wire_q.size(), 288);
    n = (wire_q.size() < exp_q.size()) ? wire_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      seg = (i < 32) ? 0 : (i < 88) ? 1 : (i < 272) ? 2 : 3;
      if (wire_q[i] !== exp_q[i]) nm[seg]++;
    end
    chk({tag, "_preamble_bad"}, nm[0], 0);
    chk({tag, "_header_bad"},   nm[1], 0);
    chk({tag, "_payload_bad"},  nm[2], 0);
    chk({tag, "_fcs_bad"},      nm[3], 0);
  endtask

  // Receive front end: the captured frame minus preamble and SFD.
  task automatic loop_rx_from_wire();
    rx_in.delete();
    for (int i = 32; i < wire_q.size(); i++) rx_in.push_back(wire_q[i]);
  endtask

  // want_kill: 0/1 fixed expectation, 2 = from model, 3 = not checked.
  task automatic run_rx(input string tag, input int want_kill);
    logic [1:0] got[$];
    logic [1:0] ro[$];
    logic [7:0] bq[$];
    logic [7:0] b;
    int n, nb, first_ov, last_ov, done_cyc, nm;
    logic kill_seen, model_kill;
    n = rx_in.size(); nb = n / 4;
    for (int j = 0; j < nb; j++) begin
      b = {rx_in[4*j+3], rx_in[4*j+2], rx_in[4*j+1], rx_in[4*j]};
      bq.push_back(b);
      for (int k = 3; k >= 0; k--) ro.push_back(b[2*k +: 2]);
    end
    model_kill = (crc_raw(bq) != 32'hDEBB_20E3);
    first_ov = -1; last_ov = -1; done_cyc = -1; kill_seen = 1'b0;
    for (int cyc = 0; cyc < n + 8; cyc++) begin
      @(negedge clk);
      if (rx_axiov) begin
        if (first_ov < 0) first_ov = cyc;
        last_ov = cyc;
        got.push_back(rx_axiod);
      end
      if (cyc >= 1 && done && done_cyc < 0) begin done_cyc = cyc; kill_seen = kill; end
      if (cyc < n) begin rx_axiiv = 1'b1; rx_axiid = rx_in[cyc]; end
      else begin rx_axiiv = 1'b0; rx_axiid = 2'b00; end
    end
    nm = 0;
    for (int i = 0; i < got.size() && i < ro.size(); i++) if (got[i] !== ro[i]) nm++;
    chk({tag, "_ov_count"}, got.size(), ro.size());
    chk({tag, "_order_bad"}, nm, 0);
    chk({tag, "_first_ov_cyc"}, first_ov, 4);
    chk({tag, "_ov_span"}, last_ov - first_ov + 1, 4 * nb);
    chk({tag, "_done_cyc"}, done_cyc, n + 1);
    if (want_kill == 2)      chk({tag, "_kill"}, kill_seen, model_kill);
    else if (want_kill != 3) chk({tag, "_kill"}, kill_seen, want_kill[0]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int hi, lo;
    bit hit;

    do_reset();
    chk("rst_phy_txen", phy_txen, 0);
    chk("rst_phy_txd", phy_txd, 0);
    chk("rst_tx_stall", tx_stall, 1);
    chk("rst_rx_axiov", rx_axiov, 0);
    chk("rst_rx_axiod", rx_axiod, 0);
    chk("rst_done", done, 0);
    chk("rst_kill", kill, 0);

    // Constant payload dibit 10 -> every payload byte is 0xAA.
    for (int i = 0; i < PD; i++) begin slot_d[i] = 2'b10; slot_v[i] = 1'b1; end
    run_tx("aa");
    check_tx("aa");
    loop_rx_from_wire();
    run_rx("lb_aa", 0);

    repeat (3) @(negedge clk);
    chk("done_hold", done, 1);

    // Same frame with one payload dibit corrupted in flight.
    rx_in[56 + 10] = rx_in[56 + 10] ^ 2'b01;
    run_rx("lb_flip", 1);

    // Random payload with an upstream gap mid-payload (zero padding).
    for (int i = 0; i < PD; i++) begin
      slot_d[i] = 2'($urandom_range(0, 3));
      slot_v[i] = !(i >= 60 && i < 80);
    end
    run_tx("gap");
    check_tx("gap");
    loop_rx_from_wire();
    run_rx("lb_gap", 0);

    // Fully random payload.
    for (int i = 0; i < PD; i++) begin slot_d[i] = 2'($urandom_range(0, 3)); slot_v[i] = 1'b1; end
    run_tx("rnd");
    check_tx("rnd");
    loop_rx_from_wire();
    run_rx("lb_rnd", 2);

    // Single byte 0x1B on the RX wire.
    rx_in = '{2'b11, 2'b10, 2'b01, 2'b00};
    run_rx("rx_1b", 2);

    // Random bytes followed by a trailing partial byte.
    rx_in.delete();
    for (int i = 0; i < 22; i++) rx_in.push_back(2'($urandom_range(0, 3)));
    run_rx("rx_partial", 3);

    // Cancel during the header.
    do_reset();
    tx_axiiv = 1'b1; tx_axiid = 2'b10;
    hi = 0; hit = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (phy_txen) hi++;
      if (hi == 40) begin hit = 1; cancelled = 1'b1; break; end
    end
    chk("cancel_reached_header", hit, 1);
    @(negedge clk);
    cancelled = 1'b0;
    chk("cancel_txen", phy_txen, 0);
    chk("cancel_stall", tx_stall, 1);
    lo = 1; hit = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (phy_txen) begin hit = 1; break; end
      lo++;
    end
    chk("cancel_restart_seen", hit, 1);
    chk("cancel_idle_cycles", lo, 48);
    chk("cancel_restart_dibit", phy_txd, 2'b01);

    // Asynchronous reset mid-frame.
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_txen", phy_txen, 0);
    chk("midrst_txd", phy_txd, 0);
    chk("midrst_stall", tx_stall, 1);
    @(negedge clk);
    tx_axiiv = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_txen", phy_txen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
